// File: rtl/visor_target_ctrl_if.sv
// Visor register port and target code-bus signals for visor_target_ctrl.
// master = visor/target side, slave = the controller.
interface visor_target_ctrl_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        tg_fetch;
  logic [15:0] tg_code_addr;
  logic        tg_reset;
  logic        tg_stall;
  logic        tg_code_sel;
  logic [15:0] tg_code_word;
  logic [3:0]  bp_hit;
  logic        visor_irq;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, tg_fetch, tg_code_addr,
    input  rd_data, tg_reset, tg_stall, tg_code_sel, tg_code_word, bp_hit, visor_irq
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, tg_fetch, tg_code_addr,
    output rd_data, tg_reset, tg_stall, tg_code_sel, tg_code_word, bp_hit, visor_irq
  );
endinterface

// File: rtl/visor_target_ctrl.sv
// Target MCU sequencer: reset hold, breakpoint halt and diverted code execution.
// Optional single-step (tg_ctrl[11]) enabled by defining VISOR_SINGLE_STEP_EN.
module visor_target_ctrl #(
  parameter int unsigned NUM_BP      = 4,
  parameter logic [15:0] BP_DISABLED = 16'hffff
) (
  input logic                clk,
  input logic                reset,
  visor_target_ctrl_if.slave bus
);
  typedef enum logic [1:0] {HELD = 2'd0, RUN = 2'd1, HALT = 2'd2, DIVERT = 2'd3} state_t;

`ifdef VISOR_SINGLE_STEP_EN
  localparam logic [15:0] CTRL_MASK = 16'hf800;
`else
  localparam logic [15:0] CTRL_MASK = 16'hf000;
`endif

  state_t      state, state_nx;
  logic [15:0] ctrl_q;
  logic [15:0] bp_q [4];
  logic [15:0] code_word_q, hit_addr_q;
  logic [3:0]  bp_hit_q, match;
  logic        skip_q, irq_q, step_q, step_start;
  logic        ctrl_wr, held_req, resume_req, consume, halt_evt, resume_evt;
  logic        ready_base, ready_nx;
  logic [15:0] ctrl_eff;

  // Control decisions use the value being written this cycle, so every
  // tg_ctrl write acts on the very next state.
  assign ctrl_wr    = bus.wr_en && (bus.wr_addr == 3'd0);
  assign ctrl_eff   = ctrl_wr ? (bus.wr_data & CTRL_MASK) : ctrl_q;
  assign held_req   = ctrl_wr && bus.wr_data[15];
  assign resume_req = ctrl_wr && bus.wr_data[12] && !bus.wr_data[14];
  assign consume    = (state == DIVERT) && ctrl_q[13] && bus.tg_fetch;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (i < NUM_BP && bp_q[i] != BP_DISABLED && bus.tg_code_addr == bp_q[i])
        match[i] = bus.tg_fetch;
  end

`ifdef VISOR_SINGLE_STEP_EN
  assign step_start = resume_req && bus.wr_data[11];
  always_ff @(posedge clk) begin
    if (reset || held_req)
      step_q <= 1'b0;
    else if (resume_evt)
      step_q <= step_start;
    else if (state == RUN && bus.tg_fetch)
      step_q <= 1'b0;
  end
`else
  assign step_start = 1'b0;
  assign step_q     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      HELD:   if (!ctrl_eff[15]) state_nx = RUN;
      RUN:    if ((step_q && bus.tg_fetch) || (|match && !skip_q)) state_nx = HALT;
      HALT:   if (ctrl_eff[14]) state_nx = DIVERT;
              else if (resume_req) state_nx = RUN;
      DIVERT: if (!ctrl_eff[14]) state_nx = HALT;
    endcase
    if (held_req) state_nx = HELD;
  end

  assign halt_evt   = (state == RUN) && (state_nx == HALT);
  assign resume_evt = (state == HALT) && (state_nx == RUN);

  // A pending code-ready is dropped whenever divert is left or cancelled.
  assign ready_base = ctrl_wr ? bus.wr_data[13] : (ctrl_q[13] && !consume);
  assign ready_nx   = ready_base && ctrl_eff[14] && (state_nx == DIVERT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HELD;
      ctrl_q      <= 16'h8000;
      for (int unsigned i = 0; i < 4; i++) bp_q[i] <= BP_DISABLED;
      code_word_q <= '0;
      hit_addr_q  <= '0;
      bp_hit_q    <= '0;
      skip_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state  <= state_nx;
      irq_q  <= halt_evt;
      ctrl_q <= {ctrl_eff[15], ctrl_eff[14] && !held_req, ready_nx,
                 ctrl_wr && bus.wr_data[12], ctrl_eff[11], 11'b0};
      for (int unsigned i = 0; i < 4; i++)
        if (i < NUM_BP && bus.wr_en && bus.wr_addr == 3'(i + 1))
          bp_q[i] <= bus.wr_data;
      if (bus.wr_en && bus.wr_addr == 3'd5)
        code_word_q <= bus.wr_data;
      if (halt_evt)
        hit_addr_q <= bus.tg_code_addr;

      if (held_req || resume_evt)
        bp_hit_q <= '0;
      else if (halt_evt)
        bp_hit_q <= step_q ? 4'b0000 : match;

      if (held_req)
        skip_q <= 1'b0;
      else if (resume_evt)
        skip_q <= !step_start;
      else if (state == RUN && bus.tg_fetch)
        skip_q <= 1'b0;
    end
  end

  assign bus.tg_reset     = (state == HELD);
  assign bus.tg_stall     = (state == HALT) || (state == DIVERT && !ctrl_q[13]);
  assign bus.tg_code_sel  = (state == DIVERT);
  assign bus.tg_code_word = code_word_q;
  assign bus.bp_hit       = bp_hit_q;
  assign bus.visor_irq    = irq_q;

  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_addr)
      3'd0: bus.rd_data = ctrl_q;
      3'd1: bus.rd_data = bp_q[0];
      3'd2: bus.rd_data = bp_q[1];
      3'd3: bus.rd_data = bp_q[2];
      3'd4: bus.rd_data = bp_q[3];
      3'd5: bus.rd_data = code_word_q;
      3'd6: bus.rd_data = {7'b0, skip_q, bp_hit_q, 2'b00, state};
      3'd7: bus.rd_data = hit_addr_q;
      default: bus.rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_visor_target_ctrl.sv
// Scoreboard bench for visor_target_ctrl: stimulus queues expectations,
// a negedge monitor compares them and every visor_irq pulse.
module tb_visor_target_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  visor_target_ctrl_if bus ();

  visor_target_ctrl #(.NUM_BP(4), .BP_DISABLED(16'hffff)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  localparam int S_RD = 0, S_RST = 1, S_STALL = 2, S_SEL = 3, S_WORD = 4, S_HIT = 5, S_IRQ = 6;

  typedef struct { string name; int sel; logic [15:0] exp; } exp_t;
  exp_t        expq [$];
  logic [3:0]  irqq [$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] sample(int sel);
    case (sel)
      S_RD:    return bus.rd_data;
      S_RST:   return {15'b0, bus.tg_reset};
      S_STALL: return {15'b0, bus.tg_stall};
      S_SEL:   return {15'b0, bus.tg_code_sel};
      S_WORD:  return bus.tg_code_word;
      S_HIT:   return {12'b0, bus.bp_hit};
      default: return {15'b0, bus.visor_irq};
    endcase
  endfunction

  exp_t        e;
  logic [3:0]  ih;
  logic [15:0] act;
  always @(negedge clk) begin
    while (expq.size() > 0) begin
      e   = expq.pop_front();
      act = sample(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
    if (bus.visor_irq === 1'b1) begin
      checks++;
      if (irqq.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected actual=1 required=0 bp_hit=%b", bus.bp_hit);
      end else begin
        ih = irqq.pop_front();
        if (bus.bp_hit !== ih) begin
          errors++;
          $display("FAIL irq_bp_hit actual=%b required=%b", bus.bp_hit, ih);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.tg_fetch = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    cyc();
  endtask

  task automatic fetch(input logic [15:0] a);
    bus.tg_fetch = 1'b1; bus.tg_code_addr = a;
    cyc();
  endtask

  task automatic chk(input string n, input int sel, input logic [15:0] v);
    expq.push_back('{n, sel, v});
  endtask

  task automatic chk_rd(input string n, input logic [2:0] a, input logic [15:0] v);
    bus.rd_addr = a;
    expq.push_back('{n, S_RD, v});
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.tg_fetch = 1'b0; bus.tg_code_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_tg_reset", S_RST, 16'h1); chk("rst_stall", S_STALL, 16'h0);
    chk("rst_code_sel", S_SEL, 16'h0); chk("rst_bp_hit", S_HIT, 16'h0);
    chk_rd("rst_ctrl", 3'd0, 16'h8000); cyc();
    for (int i = 1; i <= 4; i++) begin
      chk_rd($sformatf("rst_bp%0d", i - 1), 3'(i), 16'hffff); cyc();
    end
    chk_rd("rst_code_word", 3'd5, 16'h0000); cyc();
    chk_rd("rst_status", 3'd6, 16'h0000); cyc();
    chk_rd("rst_hit_addr", 3'd7, 16'h0000); cyc();

    // release from HELD
    wr(3'd0, 16'h0000);
    chk("run_tg_reset", S_RST, 16'h0); chk_rd("run_status", 3'd6, 16'h0001); cyc();

    // breakpoint bp2 hit
    wr(3'd3, 16'h0040);
    fetch(16'h003f);
    irqq.push_back(4'b0100);
    fetch(16'h0040);
    chk("halt_stall", S_STALL, 16'h1); chk("halt_bp_hit", S_HIT, 16'h4);
    chk_rd("halt_hit_addr", 3'd7, 16'h0040); cyc();
    chk("halt_irq_once", S_IRQ, 16'h0); chk_rd("halt_status", 3'd6, 16'h0042); cyc();

    // resume with skip_once, then re-halt
    wr(3'd0, 16'h1000);
    chk("resume_stall", S_STALL, 16'h0); chk_rd("resume_status", 3'd6, 16'h0101); cyc();
    fetch(16'h0040);
    chk("skip_no_halt", S_STALL, 16'h0); chk_rd("skip_status", 3'd6, 16'h0001); cyc();
    fetch(16'h0041);
    irqq.push_back(4'b0100);
    fetch(16'h0040);
    chk("rehalt_stall", S_STALL, 16'h1); chk_rd("rehalt_status", 3'd6, 16'h0042); cyc();

    // divert code bus
    wr(3'd0, 16'h4000);
    chk("div_sel", S_SEL, 16'h1); chk("div_stall", S_STALL, 16'h1);
    chk_rd("div_status", 3'd6, 16'h0043); cyc();
    wr(3'd5, 16'h1234);
    chk("div_word", S_WORD, 16'h1234); cyc();
    wr(3'd0, 16'h6000);
    chk("rel_stall", S_STALL, 16'h0); chk_rd("rel_ctrl", 3'd0, 16'h6000); cyc();
    chk("rel_stall_hold", S_STALL, 16'h0); cyc();
    fetch(16'h0200);
    chk("consumed_stall", S_STALL, 16'h1); chk_rd("consumed_ctrl", 3'd0, 16'h4000); cyc();
    wr(3'd0, 16'h0000);
    chk("undiv_sel", S_SEL, 16'h0); chk("undiv_stall", S_STALL, 16'h1);
    chk_rd("undiv_status", 3'd6, 16'h0042); cyc();

    // two simultaneous matches
    wr(3'd0, 16'h1000);
    wr(3'd1, 16'h0100);
    wr(3'd4, 16'h0100);
    fetch(16'h0010);
    irqq.push_back(4'b1001);
    fetch(16'h0100);
    chk("multi_bp_hit", S_HIT, 16'h9); chk_rd("multi_hit_addr", 3'd7, 16'h0100); cyc();
    chk_rd("multi_status", 3'd6, 16'h0092); cyc();

    // HELD write beats a simultaneous match
    wr(3'd0, 16'h1000);
    fetch(16'h0010);
    bus.tg_fetch = 1'b1; bus.tg_code_addr = 16'h0100;
    wr(3'd0, 16'h8000);
    chk("held_tg_reset", S_RST, 16'h1); chk("held_bp_hit", S_HIT, 16'h0);
    chk("held_stall", S_STALL, 16'h0); chk("held_no_irq", S_IRQ, 16'h0);
    chk_rd("held_status", 3'd6, 16'h0000); cyc();

    // disabled value 0xffff never matches
    wr(3'd0, 16'h0000);
    fetch(16'hffff);
    chk("disabled_stall", S_STALL, 16'h0); chk_rd("disabled_status", 3'd6, 16'h0001); cyc();
    irqq.push_back(4'b0100);
    fetch(16'h0040);
    chk_rd("halt2_status", 3'd6, 16'h0042); cyc();

`ifdef VISOR_SINGLE_STEP_EN
    wr(3'd0, 16'h1800);
    chk_rd("step_status", 3'd6, 16'h0001); cyc();
    irqq.push_back(4'b0000);
    fetch(16'h0040);
    chk("step_stall", S_STALL, 16'h1); chk_rd("step_hit_addr", 3'd7, 16'h0040); cyc();
    chk_rd("step_halt_status", 3'd6, 16'h0002); cyc();
`else
    wr(3'd0, 16'h0800);
    chk_rd("nostep_ctrl", 3'd0, 16'h0000); cyc();
    chk_rd("nostep_status", 3'd6, 16'h0042); cyc();
`endif

    repeat (3) cyc();
    checks++;
    if (irqq.size() != 0) begin
      errors++;
      $display("FAIL irq_missing actual=%0d required=0 pending", irqq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/visor_target_ctrl.md
Name: visor_target_ctrl

Overview:
- Supervisor-side control block that sequences the target MCU through reset, run, breakpoint halt and diverted-code execution.
- Holds the tg_ctrl register and the bp0..bp3 breakpoint address registers written by the visor program.
- Compares the target code address against the breakpoints, stalls the target on a hit, and arbitrates the target code bus between target ROM and visor-supplied instruction words (tg_code_ready handshake).

Parameters:
- NUM_BP, 4, breakpoint registers implemented (1..4); unimplemented slots read 0xffff.
- BP_DISABLED, 16'hffff, address value meaning "breakpoint off".

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  visor register write strobe
- wr_addr  in  3  0=tg_ctrl, 1..4=bp0..bp3_addr, 5=code_word
- wr_data  in  16  write data
- rd_addr  in  3  0=tg_ctrl, 1..4=bp regs, 5=code_word, 6=status, 7=hit_addr
- rd_data  out  16  combinational readback
- tg_fetch  in  1  target presents a valid fetch this cycle
- tg_code_addr  in  16  target fetch address
- tg_reset  out  1  hold target in reset
- tg_stall  out  1  freeze target pipeline
- tg_code_sel  out  1  1 = target code bus driven from code_word
- tg_code_word  out  16  diverted instruction word
- bp_hit  out  4  per-breakpoint match flags latched at halt
- visor_irq  out  1  one-cycle pulse on entry to HALT

Behaviour:
- tg_ctrl bits: 15 tg_reset, 14 divert_code_bus, 13 tg_code_ready (self-clearing), 12 resume (self-clearing), 11 step (optional feature); other bits read 0.
- Reset: tg_ctrl=0x8000, bp regs=0xffff, code_word=0, hit_addr=0, bp_hit=0, state=HELD, tg_reset=1, tg_stall=0, tg_code_sel=0, visor_irq=0.
- States: HELD, RUN, HALT, DIVERT.
- HELD: tg_reset=1. Leave to RUN the cycle after tg_ctrl[15] is written 0.
- Any state: writing tg_ctrl[15]=1 enters HELD next cycle.
  - Clears bp_hit, stall and divert.
  - Has priority over all other events in the same cycle.
- RUN:
  - Match = tg_fetch and tg_code_addr == bpN, with bpN != BP_DISABLED.
  - On any match: next cycle tg_stall=1, state=HALT, bp_hit=all matching slots, hit_addr=tg_code_addr, visor_irq pulses 1 cycle.
  - The matching fetch itself does not complete: stall is registered, and the target must re-issue.
  - Multiple simultaneous matches: all flags set, single irq.
- HALT:
  - tg_stall=1.
  - tg_ctrl[14]=1 → DIVERT next cycle.
  - resume=1 (with [14]=0) → RUN next cycle with bp_hit cleared and skip_once armed.
  - skip_once suppresses matching on the first tg_fetch after resume only, so the halted address can re-execute.
- DIVERT:
  - tg_code_sel=1, tg_code_word=code_word, tg_stall=1 except during a release window.
  - Writing tg_ctrl[13]=1 releases the stall: tg_stall=0 from the next cycle until the first tg_fetch.
  - On that tg_fetch, tg_stall=1 again next cycle and bit 13 auto-clears.
  - The visor polls bit 13 = 0 as "word consumed".
  - tg_ctrl[14] written 0 → HALT; tg_code_sel=0 the same next cycle.
  - If [14] is cleared while [13] is still pending, [13] is cancelled.
- Breakpoint writes while in RUN take effect for the compare on the following cycle.
- Status readback (rd_addr 6): [1:0] state code (HELD=0, RUN=1, HALT=2, DIVERT=3), [7:4] bp_hit, [8] skip_once.
- Self-clearing bits read back 0 one cycle after their effect is taken.

Optional Feature:
- Macro: VISOR_SINGLE_STEP_EN.
- Defined:
  - tg_ctrl[11] is implemented.
  - resume with step=1 enters RUN, allows exactly one completed tg_fetch, then returns to HALT with bp_hit=0, hit_addr=that fetch address, and visor_irq pulsed.
  - Step also overrides skip_once.
- Undefined: bit 11 reads 0, writes ignored, no step logic synthesized.

Test Plan:
- Reset → tg_reset=1, rd tg_ctrl=0x8000, bp1..bp4 read 0xffff; write tg_ctrl=0 → RUN, tg_reset=0 next cycle.
- bp2=0x0040, target fetches 0x003f,0x0040 → tg_stall=1 the cycle after the 0x0040 fetch, bp_hit=4'b0100, hit_addr=0x0040, one irq pulse.
- From HALT, write resume (0x1000) → RUN; refetch of 0x0040 not halted; later refetch of 0x0040 halts again.
- HALT, write 0x4000, code_word=0x1234, write 0x6000 → tg_code_sel=1, tg_code_word=0x1234, stall drops until one tg_fetch, then bit13 reads 0 and stall=1; write 0x0000 → HALT, tg_code_sel=0.
- bp0=bp3=0x0100 on the same fetch → bp_hit=4'b1001, single irq; write 0x8000 in the same cycle as a match → HELD wins, no irq, bp_hit=0.
- VISOR_SINGLE_STEP_EN: from HALT at 0x0040, write 0x1800 → one fetch of 0x0040 completes, HALT with hit_addr=0x0040, bp_hit=0.
